// File: rtl/console_input.sv
// rtl/console_input.sv - Wishbone pipelined console input device with byte FIFO and level interrupt.
module console_input #(
   parameter int FIFO_DEPTH = 16,
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic        i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_data,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_rx_ready,
   output logic        o_irq
);

   localparam int PTR_W = CNT_W - 1;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic             empty, full, push, pop, flush;
   logic [31:0]      status, rdata_next;
   logic             unused_wdata;

   assign unused_wdata = ^i_wb_data[31:1];

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign o_rx_ready = !full;
   assign o_irq      = !empty;
   assign o_wb_stall = 1'b0;

   assign push  = i_rx_valid && !full;
   assign pop   = i_wb_stb && !i_wb_we && !i_wb_addr && !empty;
   assign flush = i_wb_stb && i_wb_we && i_wb_addr && i_wb_data[0];

   always_comb begin
      status = '0;
      status[0] = !empty;
      status[1] = full;
      status[8 +: CNT_W] = count;
   end

   // Reads see pre-edge FIFO state, so an empty FIFO reports EOF even with a push in the same cycle.
   always_comb begin
      rdata_next = '0;
      if (i_wb_stb && !i_wb_we) begin
         if (i_wb_addr)
            rdata_next = status;
         else if (empty)
            rdata_next = 32'hFFFF_FFFF;
         else
            rdata_next = {24'h0, mem[rd_ptr]};
      end
   end

   always_ff @(posedge i_clk) begin
      if (push && !flush)
         mem[wr_ptr] <= i_rx_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
      end else begin
         o_wb_ack  <= i_wb_stb;
         o_wb_data <= rdata_next;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_console_input.sv
// tb/tb_console_input.sv - Randomized self-checking bench for console_input against a queue model.
module tb_console_input;

   localparam int DEPTH = 16;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_wb_stb = 1'b0;
   logic        i_wb_we = 1'b0;
   logic        i_wb_addr = 1'b0;
   logic [31:0] i_wb_data = '0;
   logic        o_wb_ack;
   logic        o_wb_stall;
   logic [31:0] o_wb_data;
   logic        i_rx_valid = 1'b0;
   logic [7:0]  i_rx_data = '0;
   logic        o_rx_ready;
   logic        o_irq;

   int errors = 0;
   int checks = 0;
   bit armed = 0;
   logic [7:0] q[$];

   always #5 i_clk = ~i_clk;

   console_input #(.FIFO_DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
      .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready), .o_irq(o_irq)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] status_of(input int n);
      return (n * 256) + ((n == DEPTH) ? 2 : 0) + ((n != 0) ? 1 : 0);
   endfunction

   // One bus cycle: model decides ack/data from pre-edge occupancy, then updates the queue.
   task automatic step(input logic rst, input logic stb, input logic we, input logic addr,
                       input logic [31:0] wd, input logic rxv, input logic [7:0] rxd);
      int n;
      logic exp_ack;
      logic [31:0] exp_data;
      i_reset = rst; i_wb_stb = stb; i_wb_we = we; i_wb_addr = addr; i_wb_data = wd;
      i_rx_valid = rxv; i_rx_data = rxd;
      #1;
      n = q.size();
      if (armed) begin
         check_eq("rx_ready", {31'b0, o_rx_ready}, {31'b0, n != DEPTH});
         check_eq("irq", {31'b0, o_irq}, {31'b0, n != 0});
      end
      exp_ack = !rst && stb;
      exp_data = 32'h0;
      if (!rst && stb && !we)
         exp_data = addr ? status_of(n) : (n == 0 ? 32'hFFFF_FFFF : {24'h0, q[0]});
      if (rst || (stb && we && addr && wd[0])) begin
         q.delete();
      end else begin
         if (stb && !we && !addr && n > 0) void'(q.pop_front());
         if (rxv && n < DEPTH) q.push_back(rxd);
      end
      @(posedge i_clk);
      #1;
      check_eq("ack", {31'b0, o_wb_ack}, {31'b0, exp_ack});
      check_eq("rdata", o_wb_data, exp_data);
      check_eq("stall", {31'b0, o_wb_stall}, 32'h0);
      armed = 1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      step(0, 0, 0, 0, 0, 1, b);
   endtask

   task automatic read_data(input logic rxv, input logic [7:0] rxd);
      step(0, 1, 0, 0, 0, rxv, rxd);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);

      step(0, 1, 0, 1, 0, 0, 0);
      check_eq("reset_status", o_wb_data, 32'h0000_0000);
      check_eq("reset_irq", {31'b0, o_irq}, 32'h0);

      push_byte(8'h41);
      push_byte(8'h42);
      read_data(0, 0);
      check_eq("read_A", o_wb_data, 32'h41);
      read_data(0, 0);
      check_eq("read_B", o_wb_data, 32'h42);
      check_eq("irq_fall", {31'b0, o_irq}, 32'h0);
      read_data(0, 0);
      check_eq("read_eof", o_wb_data, 32'hFFFF_FFFF);

      for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
      check_eq("full_ready", {31'b0, o_rx_ready}, 32'h0);
      step(0, 1, 0, 1, 0, 1, 8'h10);
      check_eq("full_status", o_wb_data, 32'h0000_1003);
      for (int k = 0; k <= DEPTH; k++) begin
         read_data(k < 2, 8'h10);
         check_eq("wrap_order", o_wb_data, 32'(k));
      end

      read_data(1, 8'h5A);
      check_eq("eof_with_push", o_wb_data, 32'hFFFF_FFFF);
      read_data(0, 0);
      check_eq("read_5A", o_wb_data, 32'h5A);

      for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
      step(0, 1, 1, 1, 32'h1, 1, 8'h77);
      step(0, 1, 0, 1, 0, 0, 0);
      check_eq("flush_status", o_wb_data, 32'h0);
      read_data(0, 0);
      check_eq("flush_eof", o_wb_data, 32'hFFFF_FFFF);

      for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
      step(1, 1, 0, 0, 0, 0, 0);
      check_eq("reset_ack", {31'b0, o_wb_ack}, 32'h0);
      check_eq("reset_irq2", {31'b0, o_irq}, 32'h0);
      read_data(0, 0);
      check_eq("reset_eof", o_wb_data, 32'hFFFF_FFFF);

      for (int i = 0; i < 600; i++) begin
         logic stb, we, addr, rxv, rst;
         logic [31:0] wd;
         rst  = ($urandom_range(99) == 0);
         stb  = ($urandom_range(2) != 0);
         we   = ($urandom_range(4) == 0);
         addr = ($urandom_range(2) == 0);
         wd   = $urandom;
         wd[0] = ($urandom_range(3) == 0);
         rxv  = ($urandom_range(2) != 0);
         step(rst, stb, we, addr, wd, rxv, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/console_input.md
Name: console_input

Overview:
- Wishbone pipelined slave that receives console input characters, the read-side counterpart of the console output device.
- A byte stream from the testbench/host side (valid/ready handshake) fills an internal FIFO.
- The CPU polls a STATUS register and pops characters from a DATA register.
- Sits on the data bus next to the console output device. Also drives a level interrupt while characters are pending.

Parameters:
FIFO_DEPTH, 16, number of buffered bytes; power of two, >= 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counter (derived, not overridden)

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous active-high reset
i_wb_stb  input  1  bus strobe
i_wb_we  input  1  1 = write, 0 = read
i_wb_addr  input  1  register select: 0 = DATA, 1 = STATUS
i_wb_data  input  32  write data
o_wb_ack  output  1  one-cycle acknowledge
o_wb_stall  output  1  tied 0
o_wb_data  output  32  read data, valid while o_wb_ack = 1
i_rx_valid  input  1  input byte present
i_rx_data  input  8  input byte
o_rx_ready  output  1  FIFO can accept a byte
o_irq  output  1  level interrupt, 1 while FIFO not empty

Behaviour:
- Reset (i_clk edge with i_reset = 1):
  - o_wb_ack = 0, o_wb_data = 0.
  - FIFO emptied: read pointer = write pointer = count = 0.
  - Reset mid-transfer discards all buffered bytes and any pending ack.
- Bus handshake:
  - o_wb_stall = 0 always; every cycle with i_wb_stb = 1 is an accepted request.
  - o_wb_ack = 1 exactly one cycle after each accepted request, otherwise 0.
  - Back-to-back strobes give back-to-back acks.
- Read data:
  - o_wb_data is registered alongside ack.
  - o_wb_data = 0 in cycles without ack.
- DATA read (addr 0, we 0):
  - If count != 0: return {24'h0, head byte}; pop one entry (read pointer +1 modulo FIFO_DEPTH, count -1).
  - If count == 0: return 32'hFFFF_FFFF (EOF) with no pop.
- STATUS read (addr 1, we 0):
  - bit0 = not empty.
  - bit1 = full.
  - bits[8+CNT_W-1:8] = count.
  - All other bits 0.
  - No side effects.
- Writes:
  - STATUS write with i_wb_data[0] = 1 flushes the FIFO (pointers and count to 0) at that edge.
  - All other writes, including any DATA write, are acked and ignored.
- FIFO push:
  - o_rx_ready = (count != FIFO_DEPTH), combinational.
  - A byte is pushed on an edge with i_rx_valid && o_rx_ready: stored at the write pointer, write pointer +1 modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - A pop uses pre-edge state: with an empty FIFO plus a simultaneous push, the read returns EOF and the pushed byte stays buffered.
- Push while full: cannot occur (ready low); the source holds its byte.
- Flush in the same cycle as a push: flush wins, the pushed byte is discarded, count = 0 after the edge.
- Pointers: CNT_W-1 bits, wrap naturally. count never exceeds FIFO_DEPTH or underflows.
- o_irq = (count != 0), combinational from registered count.

Test Plan:
- Reset, then STATUS read -> ack one cycle later, data 32'h0000_0000; o_rx_ready = 1, o_irq = 0.
- Push 'A','B' (0x41, 0x42), then 3 DATA reads -> 32'h41, 32'h42, 32'hFFFF_FFFF; o_irq falls after the second read's edge.
- Push 16 bytes 0x00..0x0F with FIFO_DEPTH = 16:
  - o_rx_ready = 0; STATUS = 32'h0000_1003 (count 16, full, not empty).
  - 17th byte held by the source, accepted one cycle after the next DATA read.
  - Reads return 0x00..0x0F in order across the pointer wrap.
- Empty FIFO, DATA read and push of 0x5A in the same cycle -> read returns 32'hFFFF_FFFF; the next read returns 32'h5A.
- 5 bytes buffered, STATUS write 32'h1 while i_rx_valid = 1 -> count = 0, the concurrent byte dropped, the next DATA read returns EOF.
- Hold i_reset with 3 bytes buffered and a read in flight -> o_wb_ack = 0 that cycle, FIFO empty afterwards, o_irq = 0.
